// File: rtl/cfg_chain_shifter.sv
// Serial configuration/scan chain engine. Holds a word-addressed chain image, shifts it out MSB-first,
// captures the returned serial stream into a readback image and optionally pulses the load strobe.
module cfg_chain_shifter #(
  parameter int CHAIN_LEN = 768,
  parameter int WORD_W    = 32,
  parameter int CLK_DIV_W = 8,
  parameter int AW        = $clog2(CHAIN_LEN / WORD_W)
) (
  input  logic                           S_AXI_ACLK,
  input  logic                           S_AXI_ARESETN,
  input  logic                           wr_en,
  input  logic [AW-1:0]                  wr_addr,
  input  logic [WORD_W-1:0]              wr_data,
  input  logic [AW-1:0]                  rd_addr,
  output logic [WORD_W-1:0]              rd_data,
  input  logic [CLK_DIV_W-1:0]           clk_div,
  input  logic                           load_en,
  input  logic                           start,
  input  logic                           abort,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(CHAIN_LEN+1)-1:0] bit_cnt,
  output logic                           ser_clk,
  output logic                           ser_out,
  output logic                           ser_load,
  input  logic                           ser_in
);

  localparam int NWORDS = CHAIN_LEN / WORD_W;
  localparam int CW     = $clog2(CHAIN_LEN + 1);
  localparam int IW     = $clog2(CHAIN_LEN);
  localparam int PW     = CLK_DIV_W + 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SHIFT_LO = 3'd1,
    S_SHIFT_HI = 3'd2,
    S_LOAD     = 3'd3,
    S_FINISH   = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  state_e               state_q;
  logic [CLK_DIV_W-1:0] div_q;
  logic                 load_q;
  logic [PW-1:0]        ph_q;
  logic [CW-1:0]        bit_cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 ser_clk_q;
  logic                 ser_out_q;
  logic                 ser_load_q;
  logic [CHAIN_LEN-1:0] image_q;
  logic [CHAIN_LEN-1:0] rb_q;
  logic [WORD_W-1:0]    rd_data_q;

  logic [IW-1:0]        wr_base_s;
  logic [IW-1:0]        rd_base_s;
  logic [IW-1:0]        cap_idx_s;
  logic [IW-1:0]        nxt_idx_s;
  logic                 wr_ok_s;
  logic                 rd_ok_s;
  logic                 half_end_s;
  logic                 full_end_s;
  logic                 last_bit_s;

  // Word address decode, bit pointers into the chain and phase-end decode.
  always_comb begin
    wr_base_s  = IW'(wr_addr) * IW'(WORD_W);
    rd_base_s  = IW'(rd_addr) * IW'(WORD_W);
    wr_ok_s    = (32'(wr_addr) < 32'(NWORDS));
    rd_ok_s    = (32'(rd_addr) < 32'(NWORDS));
    // Bit k of the stream lives at chain position CHAIN_LEN-1-k.
    cap_idx_s  = IW'(CHAIN_LEN - 1) - IW'(bit_cnt_q);
    nxt_idx_s  = cap_idx_s - IW'(1);
    half_end_s = (ph_q == {1'b0, div_q});
    full_end_s = (ph_q == {div_q, 1'b1});
    last_bit_s = (bit_cnt_q == CW'(CHAIN_LEN - 1));
  end

  // Image buffer; host writes are dropped while an operation runs.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      image_q <= '0;
    end else if (wr_en && !busy_q && wr_ok_s) begin
      image_q[wr_base_s +: WORD_W] <= wr_data;
    end
  end

  // Registered readback word port.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_data_q <= '0;
    end else if (rd_ok_s) begin
      rd_data_q <= rb_q[rd_base_s +: WORD_W];
    end else begin
      rd_data_q <= '0;
    end
  end

  // Shift sequencer: phase timing, serial pins, readback capture and status.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      load_q     <= 1'b0;
      ph_q       <= '0;
      bit_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ser_clk_q  <= 1'b0;
      ser_out_q  <= 1'b0;
      ser_load_q <= 1'b0;
      rb_q       <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        // Abort outranks everything; bit_cnt and the partial readback are kept.
        state_q    <= S_IDLE;
        ph_q       <= '0;
        busy_q     <= 1'b0;
        ser_clk_q  <= 1'b0;
        ser_out_q  <= 1'b0;
        ser_load_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              div_q     <= clk_div;
              load_q    <= load_en;
              ph_q      <= '0;
              bit_cnt_q <= '0;
              busy_q    <= 1'b1;
              ser_clk_q <= 1'b0;
              ser_out_q <= image_q[CHAIN_LEN-1];
              state_q   <= S_SHIFT_LO;
            end
          end
          S_SHIFT_LO: begin
            if (half_end_s) begin
              ph_q      <= '0;
              ser_clk_q <= 1'b1;
              state_q   <= S_SHIFT_HI;
            end else begin
              ph_q <= ph_q + PW'(1);
            end
          end
          S_SHIFT_HI: begin
            if (half_end_s) begin
              ph_q            <= '0;
              ser_clk_q       <= 1'b0;
              rb_q[cap_idx_s] <= ser_in;
              bit_cnt_q       <= bit_cnt_q + CW'(1);
              if (last_bit_s) begin
                ser_out_q  <= 1'b0;
                ser_load_q <= load_q;
                state_q    <= load_q ? S_LOAD : S_FINISH;
              end else begin
                ser_out_q <= image_q[nxt_idx_s];
                state_q   <= S_SHIFT_LO;
              end
            end else begin
              ph_q <= ph_q + PW'(1);
            end
          end
          S_LOAD, S_FINISH: begin
            // Both tails last 2(D+1) cycles so total latency ignores load_en.
            if (full_end_s) begin
              ph_q       <= '0;
              ser_load_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              ph_q <= ph_q + PW'(1);
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            ser_clk_q  <= 1'b0;
            ser_out_q  <= 1'b0;
            ser_load_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign bit_cnt  = bit_cnt_q;
  assign ser_clk  = ser_clk_q;
  assign ser_out  = ser_out_q;
  assign ser_load = ser_load_q;

endmodule
